// File: rtl/game_pkg.sv
// Shared game constants: lane count, target index type, score floor and the
// default target lifetime. Used by the generator, target_tracker and the
// display driver so all three agree on the lane numbering.
package game_pkg;

    localparam int NUM_TARGETS      = 10;
    localparam int LIFETIME_DEFAULT = 50000000;
    localparam int SCORE_W_DEFAULT  = 32;
    localparam int MISS_W_DEFAULT   = 16;

    // The generator divides by the score, so it must never reach zero.
    localparam int SCORE_MIN = 1;

    typedef logic [3:0] target_idx_t;

endpackage

// File: rtl/target_slot.sv
// One target lane: idle/active bit plus a countdown that runs while lit.
// hit and expire are combinational views of this cycle's start-of-cycle
// state; the lane itself clears at the next edge. A hit always beats an
// expiry, and a spawn request is only honoured when the lane is idle.
module target_slot
    import game_pkg::*;
#(
    parameter int LIFETIME = LIFETIME_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic spawn,
    input  logic hit_rise,
    output logic active,
    output logic expire,
    output logic hit
);

    localparam int CNT_W = $clog2(LIFETIME);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;

    assign active = active_q;
    assign hit    = active_q & hit_rise;
    assign expire = active_q & (cnt_q == '0) & ~hit_rise;

    // Lane state: clear on hit/expiry, load on spawn when idle, else count down.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (hit || expire) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q - 1'b1;
        end else if (spawn) begin
            active_q <= 1'b1;
            cnt_q    <= CNT_W'(LIFETIME - 1);
        end
    end

endmodule

// File: rtl/target_tracker.sv
// Target tracker: lights lanes on generator strobes, times them out, scores
// rising button edges against lit lanes and keeps a floored/saturating score
// and a saturating miss count. The per-lane active bits are the only state
// machine and are visible directly on the active output.
// Optional build macro TARGET_TRACKER_WRONG_PRESS_PENALTY_EN: a rising edge on
// an idle lane costs one point (score never drops below SCORE_MIN).
// Interface note: target_stb is a single-cycle qualifier for target_sel with
// no back-pressure; a strobe that cannot be used (bad index, busy lane) is
// simply dropped.
module target_tracker
    import game_pkg::*;
#(
    parameter int NUM_TARGETS = game_pkg::NUM_TARGETS,
    parameter int LIFETIME    = LIFETIME_DEFAULT,
    parameter int SCORE_W     = SCORE_W_DEFAULT,
    parameter int MISS_W      = MISS_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  target_idx_t            target_sel,
    input  logic                   target_stb,
    input  logic [NUM_TARGETS-1:0] hit_btn,
    output logic [NUM_TARGETS-1:0] active,
    output logic [SCORE_W-1:0]     score,
    output logic [MISS_W-1:0]      misses,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);

    localparam int CNT_W = $clog2(NUM_TARGETS + 1);

    logic [NUM_TARGETS-1:0] btn_prev_q;
    logic [NUM_TARGETS-1:0] rise;
    logic [NUM_TARGETS-1:0] spawn_req;
    logic [NUM_TARGETS-1:0] hit_v;
    logic [NUM_TARGETS-1:0] exp_v;

    logic [CNT_W-1:0]   n_hit;
    logic [CNT_W-1:0]   n_exp;
    logic [CNT_W-1:0]   n_pen;
    logic [SCORE_W+1:0] sum_w;
    logic [SCORE_W+1:0] net_w;
    logic [MISS_W:0]    miss_w;
    logic [SCORE_W-1:0] score_d;
    logic [MISS_W-1:0]  misses_d;

    assign rise = hit_btn & ~btn_prev_q;

    genvar g;
    generate
        for (g = 0; g < NUM_TARGETS; g++) begin : g_lane
            assign spawn_req[g] = target_stb && (int'(target_sel) == g);

            target_slot #(
                .LIFETIME (LIFETIME)
            ) u_slot (
                .clock    (clock),
                .resetn   (resetn),
                .spawn    (spawn_req[g]),
                .hit_rise (rise[g]),
                .active   (active[g]),
                .expire   (exp_v[g]),
                .hit      (hit_v[g])
            );
        end
    endgenerate

`ifdef TARGET_TRACKER_WRONG_PRESS_PENALTY_EN
    logic [NUM_TARGETS-1:0] wrong_v;
    assign wrong_v = rise & ~active;

    // Count wrong presses (rising edges on idle lanes).
    always_comb begin
        n_pen = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            n_pen = n_pen + CNT_W'(wrong_v[i]);
        end
    end
`else
    assign n_pen = '0;
`endif

    // Popcount hits and expiries, then form the next score and miss count.
    always_comb begin
        n_hit = '0;
        n_exp = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            n_hit = n_hit + CNT_W'(hit_v[i]);
            n_exp = n_exp + CNT_W'(exp_v[i]);
        end

        // Hits and penalties net first, then floor and saturate.
        sum_w   = {2'b00, score} + (SCORE_W + 2)'(n_hit);
        net_w   = '0;
        score_d = score;
        if (sum_w < (SCORE_W + 2)'(n_pen) + (SCORE_W + 2)'(SCORE_MIN)) begin
            score_d = SCORE_W'(SCORE_MIN);
        end else begin
            net_w = sum_w - (SCORE_W + 2)'(n_pen);
            if (net_w > {2'b00, {SCORE_W{1'b1}}}) begin
                score_d = '1;
            end else begin
                score_d = net_w[SCORE_W-1:0];
            end
        end

        miss_w = {1'b0, misses} + (MISS_W + 1)'(n_exp);
        if (miss_w[MISS_W]) begin
            misses_d = '1;
        end else begin
            misses_d = miss_w[MISS_W-1:0];
        end
    end

    // Register button history, score, miss count and the event pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            btn_prev_q <= '0;
            score      <= SCORE_W'(SCORE_MIN);
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            btn_prev_q <= hit_btn;
            score      <= score_d;
            misses     <= misses_d;
            hit_pulse  <= |hit_v;
            miss_pulse <= |exp_v;
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
module tb_target_tracker;

    localparam int NT = 10;
    localparam int LT = 8;
    localparam int SW = 32;
    localparam int MW = 16;
    localparam longint SCORE_MAX = (64'd1 << SW) - 1;
    localparam longint MISS_MAX  = (64'd1 << MW) - 1;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    target_sel = '0;
    logic          target_stb = 1'b0;
    logic [NT-1:0] hit_btn = '0;
    logic [NT-1:0] active;
    logic [SW-1:0] score;
    logic [MW-1:0] misses;
    logic          hit_pulse;
    logic          miss_pulse;

    int checks = 0;
    int errors = 0;

    target_tracker #(
        .NUM_TARGETS (NT),
        .LIFETIME    (LT),
        .SCORE_W     (SW),
        .MISS_W      (MW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .target_sel (target_sel),
        .target_stb (target_stb),
        .hit_btn    (hit_btn),
        .active     (active),
        .score      (score),
        .misses     (misses),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    // ---------------- clock / timeout ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (limit 2000000)");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Each lit lane remembers the edge number it was lit at; it expires at
    // the edge LT later unless a rising press removed it first.
    bit     m_active [NT];
    int     m_spawn  [NT];
    bit     m_prev   [NT];
    longint m_score;
    longint m_miss;
    bit     m_hp;
    bit     m_mp;
    int     edge_n;

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) begin
            m_active[i] = 0;
            m_spawn[i]  = 0;
            m_prev[i]   = 0;
        end
        m_score = 1;
        m_miss  = 0;
        m_hp    = 0;
        m_mp    = 0;
        edge_n  = 0;
    endfunction

    function automatic void model_step(logic stb, logic [3:0] sel, logic [NT-1:0] btn);
        int hits = 0;
        int exps = 0;
        int pen  = 0;
        longint s;
        edge_n++;
        for (int i = 0; i < NT; i++) begin
            bit r;
            r = btn[i] && !m_prev[i];
            if (m_active[i]) begin
                if (r) begin
                    hits++;
                    m_active[i] = 0;
                end else if (edge_n - m_spawn[i] == LT) begin
                    exps++;
                    m_active[i] = 0;
                end
            end else begin
                if (r) pen++;
                if (stb && int'(sel) == i) begin
                    m_active[i] = 1;
                    m_spawn[i]  = edge_n;
                end
            end
            m_prev[i] = btn[i];
        end
`ifndef TARGET_TRACKER_WRONG_PRESS_PENALTY_EN
        pen = 0;
`endif
        s = m_score + hits - pen;
        if (s < 1) s = 1;
        if (s > SCORE_MAX) s = SCORE_MAX;
        m_score = s;
        m_miss = m_miss + exps;
        if (m_miss > MISS_MAX) m_miss = MISS_MAX;
        m_hp = (hits > 0);
        m_mp = (exps > 0);
    endfunction

    function automatic logic [NT-1:0] model_active();
        logic [NT-1:0] v;
        for (int i = 0; i < NT; i++) v[i] = m_active[i];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives inputs, lets one rising edge pass,
    // advances the model, returns at the next falling edge.
    task automatic cycle(input logic stb, input logic [3:0] sel, input logic [NT-1:0] btn);
        target_stb = stb;
        target_sel = sel;
        hit_btn    = btn;
        @(posedge clock);
        model_step(stb, sel, btn);
        @(negedge clock);
    endtask

    task automatic reset_dut();
        resetn     = 1'b0;
        target_stb = 1'b0;
        target_sel = '0;
        hit_btn    = '0;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        checks++;
        if (active !== '0 || score !== 32'd1 || misses !== 16'd0 ||
            hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: active=%h score=%0d misses=%0d hp=%b mp=%b expected 000 1 0 0 0",
                     active, score, misses, hit_pulse, miss_pulse);
        end
    endtask

    task automatic test_lifetime();
        int cnt = 0;
        reset_dut();
        cycle(1'b1, 4'd3, '0);
        checks++;
        if (active !== 10'h008) begin
            errors++;
            $display("FAIL spawn_latency: active=%h expected 008", active);
        end
        if (active[3]) cnt = 1;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'd0, '0);
            if (active[3]) cnt++;
            else break;
        end
        checks++;
        if (cnt != LT) begin
            errors++;
            $display("FAIL lifetime_len: lit %0d cycles expected %0d", cnt, LT);
        end
        checks++;
        if (misses !== 16'd1 || miss_pulse !== 1'b1) begin
            errors++;
            $display("FAIL expiry_event: misses=%0d mp=%b expected 1 1", misses, miss_pulse);
        end
        cycle(1'b0, 4'd0, '0);
        checks++;
        if (miss_pulse !== 1'b0 || misses !== 16'd1) begin
            errors++;
            $display("FAIL miss_pulse_width: mp=%b misses=%0d expected 0 1", miss_pulse, misses);
        end
    endtask

    task automatic test_double_hit();
        reset_dut();
        cycle(1'b1, 4'd2, '0);
        cycle(1'b1, 4'd5, '0);
        cycle(1'b0, 4'd0, 10'h024);
        checks++;
        if (score !== 32'd3 || hit_pulse !== 1'b1 || active !== '0) begin
            errors++;
            $display("FAIL double_hit: score=%0d hp=%b active=%h expected 3 1 000",
                     score, hit_pulse, active);
        end
        cycle(1'b0, 4'd0, 10'h024);
        checks++;
        if (score !== 32'd3 || hit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL double_hit_after: score=%0d hp=%b expected 3 0", score, hit_pulse);
        end
        cycle(1'b0, 4'd0, '0);
    endtask

    task automatic test_held_button();
        int hp_cnt = 0;
        reset_dut();
        cycle(1'b1, 4'd4, '0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'd0, 10'h010);
            if (hit_pulse) hp_cnt++;
        end
        checks++;
        if (score !== 32'd2 || hp_cnt != 1) begin
            errors++;
            $display("FAIL held_button: score=%0d pulses=%0d expected 2 1", score, hp_cnt);
        end
        cycle(1'b0, 4'd0, '0);
        // Lane lit, then pressed exactly in its last lit cycle.
        cycle(1'b1, 4'd4, '0);
        repeat (LT - 1) cycle(1'b0, 4'd0, '0);
        checks++;
        if (active[4] !== 1'b1) begin
            errors++;
            $display("FAIL last_cycle_lit: active[4]=%b expected 1", active[4]);
        end
        cycle(1'b0, 4'd0, 10'h010);
        checks++;
        if (score !== 32'd3 || misses !== 16'd0 || hit_pulse !== 1'b1 ||
            miss_pulse !== 1'b0 || active[4] !== 1'b0) begin
            errors++;
            $display("FAIL hit_on_expiry: score=%0d misses=%0d hp=%b mp=%b a4=%b expected 3 0 1 0 0",
                     score, misses, hit_pulse, miss_pulse, active[4]);
        end
        cycle(1'b0, 4'd0, '0);
    endtask

    task automatic test_bad_and_restrobe();
        int cnt = 0;
        reset_dut();
        cycle(1'b1, 4'd12, '0);
        checks++;
        if (active !== '0 || score !== 32'd1 || misses !== 16'd0) begin
            errors++;
            $display("FAIL bad_index: active=%h score=%0d misses=%0d expected 000 1 0",
                     active, score, misses);
        end
        cycle(1'b1, 4'd3, '0);
        if (active[3]) cnt = 1;
        for (int k = 0; k < 20; k++) begin
            cycle((k == 2), 4'd3, '0);
            if (active[3]) cnt++;
            else break;
        end
        checks++;
        if (cnt != LT || misses !== 16'd1) begin
            errors++;
            $display("FAIL restrobe_no_reload: lit %0d misses=%0d expected %0d 1", cnt, misses, LT);
        end
    endtask

    task automatic test_wrong_press();
        logic [SW-1:0] exp_s;
        reset_dut();
        cycle(1'b0, 4'd0, 10'h001);
        checks++;
        if (score !== 32'd1) begin
            errors++;
            $display("FAIL penalty_floor: score=%0d expected 1", score);
        end
        cycle(1'b0, 4'd0, '0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), '0);
        cycle(1'b0, 4'd0, 10'h01E);
        checks++;
        if (score !== 32'd5) begin
            errors++;
            $display("FAIL four_hits: score=%0d expected 5", score);
        end
        cycle(1'b0, 4'd0, '0);
        cycle(1'b0, 4'd0, 10'h001);
`ifdef TARGET_TRACKER_WRONG_PRESS_PENALTY_EN
        exp_s = 32'd4;
`else
        exp_s = 32'd5;
`endif
        checks++;
        if (score !== exp_s) begin
            errors++;
            $display("FAIL wrong_press: score=%0d expected %0d", score, exp_s);
        end
        cycle(1'b0, 4'd0, '0);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i), '0);
        cycle(1'b0, 4'd0, 10'h03F);
        cycle(1'b0, 4'd0, '0);
        for (int i = 7; i < 10; i++) cycle(1'b1, 4'(i), '0);
        cycle(1'b0, 4'd0, 10'h002);
        checks++;
        if (active !== 10'h380 || score !== 32'd7) begin
            errors++;
            $display("FAIL pre_reset_state: active=%h score=%0d expected 380 7", active, score);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (active !== '0 || score !== 32'd1 || misses !== 16'd0 ||
            hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: active=%h score=%0d misses=%0d hp=%b mp=%b expected 000 1 0 0 0",
                     active, score, misses, hit_pulse, miss_pulse);
        end
        // Button 1 stays held across reset release; its first sample is a rise.
        @(negedge clock);
        model_reset();
        target_stb = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        cycle(1'b1, 4'd1, 10'h002);
        checks++;
        if (active !== model_active() || score !== m_score[SW-1:0]) begin
            errors++;
            $display("FAIL held_through_reset: active=%h score=%0d expected %h %0d",
                     active, score, model_active(), m_score);
        end
        cycle(1'b0, 4'd0, '0);
    endtask

    task automatic test_random();
        logic [NT-1:0] btn = '0;
        logic          stb;
        logic [3:0]    sel;
        reset_dut();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NT; i++) begin
                if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
            end
            stb = ($urandom_range(0, 2) == 0);
            sel = 4'($urandom_range(0, 15));
            cycle(stb, sel, btn);
            checks++;
            if (active !== model_active() || score !== m_score[SW-1:0] ||
                misses !== m_miss[MW-1:0] || hit_pulse !== m_hp || miss_pulse !== m_mp) begin
                errors++;
                $display("FAIL random_cycle%0d: active=%h score=%0d misses=%0d hp=%b mp=%b expected %h %0d %0d %b %b",
                         k, active, score, misses, hit_pulse, miss_pulse,
                         model_active(), m_score, m_miss, m_hp, m_mp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clock);
        test_reset();
        test_lifetime();
        test_double_hit();
        test_held_button();
        test_bad_and_restrobe();
        test_wrong_press();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
